// File: rtl/reg_rename_table.sv
// Register rename stage: arch-to-phys map, circular free list of destination tags,
// and a per-physical-register busy vector. Source lookups are combinational.
module reg_rename_table #(
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned PW       = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                i_uses_rs,
  input  logic                i_uses_rt,
  input  logic                i_uses_rw,
  input  logic [4:0]          i_rs_addr,
  input  logic [4:0]          i_rt_addr,
  input  logic [4:0]          i_rw_addr,
  output logic                o_stall,
  output logic [PW-1:0]       o_rs_phys,
  output logic [PW-1:0]       o_rt_phys,
  output logic [PW-1:0]       o_rw_phys,
  output logic [PW-1:0]       o_old_rw_phys,
  output logic [NUM_PHYS-1:0] o_busy_bits,
  input  logic                i_wb_valid,
  input  logic [PW-1:0]       i_wb_phys,
  input  logic                i_free_valid,
  input  logic [PW-1:0]       i_free_phys,
  output logic [PW-1:0]       o_free_count,
  output logic                o_overflow
);

  localparam int unsigned FlDepth = NUM_PHYS - NUM_ARCH;
  localparam int unsigned FlW     = (FlDepth > 1) ? $clog2(FlDepth) : 1;

  logic [PW-1:0]       map_q [NUM_ARCH];
  logic [PW-1:0]       map_d [NUM_ARCH];
  logic [PW-1:0]       fl_q  [FlDepth];
  logic [PW-1:0]       fl_d  [FlDepth];
  logic [NUM_PHYS-1:0] busy_q, busy_d;
  logic [FlW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;

  logic          alloc, alloc_ok, free_req, free_ok, cnt_empty, cnt_full;
  logic [PW-1:0] new_tag;

  // Source-use flags are not needed: lookups are always performed.
  logic unused_src_flags;
  assign unused_src_flags = i_uses_rs ^ i_uses_rt;

  function automatic logic [FlW-1:0] next_ptr(input logic [FlW-1:0] p);
    return (p == FlW'(FlDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign alloc     = i_valid & i_uses_rw & (i_rw_addr != '0);
  assign cnt_empty = (count_q == '0);
  assign cnt_full  = (count_q == PW'(FlDepth));
  assign alloc_ok  = alloc & ~cnt_empty;
  assign free_req  = i_free_valid & (i_free_phys != '0);
  // A full list still has room for a free when an allocation drains a slot this cycle.
  assign free_ok   = free_req & (~cnt_full | alloc_ok);
  assign new_tag   = fl_q[head_q];

  assign o_stall       = alloc & cnt_empty;
  assign o_rs_phys     = map_q[i_rs_addr];
  assign o_rt_phys     = map_q[i_rt_addr];
  assign o_old_rw_phys = map_q[i_rw_addr];
  assign o_rw_phys     = alloc ? new_tag : '0;
  assign o_busy_bits   = busy_q;
  assign o_free_count  = count_q;
  assign o_overflow    = ovf_q;

  always_comb begin
    map_d   = map_q;
    fl_d    = fl_q;
    busy_d  = busy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_wb_valid && (i_wb_phys != '0)) busy_d[i_wb_phys] = 1'b0;
    // Applied after the writeback clear so a same-tag set wins.
    if (alloc_ok) begin
      map_d[i_rw_addr] = new_tag;
      busy_d[new_tag]  = 1'b1;
      head_d           = next_ptr(head_q);
    end
    if (free_ok) begin
      fl_d[tail_q] = i_free_phys;
      tail_d       = next_ptr(tail_q);
    end else if (free_req) begin
      ovf_d = 1'b1;
    end
    case ({alloc_ok, free_ok})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= PW'(i);
      for (int k = 0; k < FlDepth; k++) fl_q[k] <= PW'(NUM_ARCH + k);
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= PW'(FlDepth);
      ovf_q   <= 1'b0;
    end else begin
      map_q   <= map_d;
      fl_q    <= fl_d;
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_reg_rename_table.sv
// Scoreboard bench for reg_rename_table: stimulus queues expected outputs per cycle,
// a monitor compares them at the falling edge.
module tb_reg_rename_table;

  logic        clk, rst;
  logic        i_valid, i_uses_rs, i_uses_rt, i_uses_rw;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rw_addr;
  logic        o_stall;
  logic [5:0]  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
  logic [63:0] o_busy_bits;
  logic        i_wb_valid, i_free_valid;
  logic [5:0]  i_wb_phys, i_free_phys;
  logic [5:0]  o_free_count;
  logic        o_overflow;

  reg_rename_table dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_uses_rs    (i_uses_rs),
    .i_uses_rt    (i_uses_rt),
    .i_uses_rw    (i_uses_rw),
    .i_rs_addr    (i_rs_addr),
    .i_rt_addr    (i_rt_addr),
    .i_rw_addr    (i_rw_addr),
    .o_stall      (o_stall),
    .o_rs_phys    (o_rs_phys),
    .o_rt_phys    (o_rt_phys),
    .o_rw_phys    (o_rw_phys),
    .o_old_rw_phys(o_old_rw_phys),
    .o_busy_bits  (o_busy_bits),
    .i_wb_valid   (i_wb_valid),
    .i_wb_phys    (i_wb_phys),
    .i_free_valid (i_free_valid),
    .i_free_phys  (i_free_phys),
    .o_free_count (o_free_count),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 in any field means "not checked this cycle".
  typedef struct {
    string name;
    int    stall, rs, rt, rw, old, cnt, ovf, bidx, bval, bzero;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t blank(input string n);
    exp_t e;
    e.name = n;
    e.stall = -1; e.rs = -1; e.rt = -1; e.rw = -1; e.old = -1;
    e.cnt = -1; e.ovf = -1; e.bidx = -1; e.bval = -1; e.bzero = -1;
    return e;
  endfunction

  task automatic chk(input string n, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.stall >= 0) chk({e.name, ".stall"}, int'(o_stall), e.stall);
        if (e.rs >= 0)    chk({e.name, ".rs_phys"}, int'(o_rs_phys), e.rs);
        if (e.rt >= 0)    chk({e.name, ".rt_phys"}, int'(o_rt_phys), e.rt);
        if (e.rw >= 0)    chk({e.name, ".rw_phys"}, int'(o_rw_phys), e.rw);
        if (e.old >= 0)   chk({e.name, ".old_rw_phys"}, int'(o_old_rw_phys), e.old);
        if (e.cnt >= 0)   chk({e.name, ".free_count"}, int'(o_free_count), e.cnt);
        if (e.ovf >= 0)   chk({e.name, ".overflow"}, int'(o_overflow), e.ovf);
        if (e.bidx >= 0)  chk({e.name, ".busy_bit"}, int'(o_busy_bits[e.bidx]), e.bval);
        if (e.bzero >= 0) chk({e.name, ".busy_all_zero"}, int'(o_busy_bits == '0), e.bzero);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic v, input logic urw, input int rs, input int rt,
                       input int rw);
    i_valid      = v;
    i_uses_rs    = v;
    i_uses_rt    = v;
    i_uses_rw    = urw;
    i_rs_addr    = 5'(rs);
    i_rt_addr    = 5'(rt);
    i_rw_addr    = 5'(rw);
    i_wb_valid   = 1'b0;
    i_wb_phys    = '0;
    i_free_valid = 1'b0;
    i_free_phys  = '0;
  endtask

  task automatic issue(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   f;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    do_reset();

    // Reset state and plain lookup
    drive(1'b1, 1'b0, 5, 0, 0);
    e = blank("reset"); e.cnt = 32; e.bzero = 1; e.rs = 5; e.stall = 0; e.ovf = 0; e.rw = 0;
    issue(e);

    // Dependent chain
    drive(1'b1, 1'b1, 1, 2, 3);
    e = blank("chain_add3"); e.rw = 32; e.old = 3; e.rs = 1; e.rt = 2; e.stall = 0; e.cnt = 32;
    issue(e);
    drive(1'b1, 1'b0, 3, 0, 0);
    i_wb_valid = 1'b1; i_wb_phys = 6'd32;
    e = blank("chain_dep"); e.rs = 32; e.rt = 0; e.bidx = 32; e.bval = 1; e.cnt = 31;
    issue(e);
    drive(1'b0, 1'b0, 0, 0, 0);
    e = blank("chain_wb"); e.bidx = 32; e.bval = 0; e.bzero = 1; e.cnt = 31;
    issue(e);

    // Same register as source and destination
    do_reset();
    drive(1'b1, 1'b1, 7, 7, 7);
    e = blank("same_reg"); e.rs = 7; e.rt = 7; e.rw = 32; e.old = 7; e.cnt = 32;
    issue(e);
    drive(1'b1, 1'b0, 7, 0, 0);
    e = blank("same_reg_next"); e.rs = 32; e.bidx = 32; e.bval = 1; e.cnt = 31;
    issue(e);

    // Exhaustion and recovery
    do_reset();
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b1, 0, 0, (k % 31) + 1);
      e = blank("exhaust"); e.rw = 32 + k; e.cnt = 32 - k; e.stall = 0;
      issue(e);
    end
    drive(1'b1, 1'b1, 0, 0, 5);
    i_free_valid = 1'b1; i_free_phys = 6'd40;
    e = blank("stall_with_free"); e.stall = 1; e.cnt = 0; e.old = 36;
    issue(e);
    drive(1'b1, 1'b1, 0, 0, 5);
    e = blank("recover"); e.stall = 0; e.rw = 40; e.cnt = 1; e.old = 36;
    issue(e);
    drive(1'b0, 1'b0, 5, 0, 0);
    e = blank("recover_map"); e.rs = 40; e.cnt = 0; e.bidx = 40; e.bval = 1;
    issue(e);

    // Wrap with paired alloc/free, then $zero destination
    do_reset();
    for (int k = 0; k < 40; k++) begin
      f = (k % 31) + 1;
      drive(1'b1, 1'b1, 0, 0, f);
      i_free_valid = 1'b1; i_free_phys = 6'(f);
      e = blank("wrap"); e.rw = (k < 32) ? 32 + k : k - 31; e.cnt = 32; e.stall = 0; e.ovf = 0;
      issue(e);
    end
    drive(1'b1, 1'b1, 0, 0, 0);
    e = blank("zero_dst"); e.rw = 0; e.cnt = 32; e.rs = 0; e.stall = 0;
    issue(e);
    drive(1'b0, 1'b0, 0, 0, 0);
    e = blank("zero_map"); e.rs = 0; e.cnt = 32; e.bidx = 0; e.bval = 0;
    issue(e);

    // Overflow is sticky until reset
    drive(1'b0, 1'b0, 0, 0, 0);
    i_free_valid = 1'b1; i_free_phys = 6'd50;
    e = blank("ovf_free"); e.cnt = 32; e.ovf = 0;
    issue(e);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 0, 0, 0);
      e = blank("ovf_sticky"); e.cnt = 32; e.ovf = 1;
      issue(e);
    end
    do_reset();
    drive(1'b0, 1'b0, 0, 0, 0);
    e = blank("ovf_reset"); e.cnt = 32; e.ovf = 0; e.bzero = 1;
    issue(e);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
